// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit PC generator.
package ifu_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FLUSH = 3'd4
    } ifu_state_e;

    // Sequential fetch stride (one 32-bit instruction).
    localparam logic [31:0] IFU_PC_STEP = 32'd4;

    // Default first fetch address after reset.
    localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_pc_gen_if.sv
// Bundle of the redirect, I-cache and IDU-facing signals of the fetch PC generator.
interface ifu_pc_gen_if;

    logic        dnpc_flag;
    logic [31:0] dnpc;
    logic        icache_clr;

    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;

    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;

    logic        icache_flush;
    logic        icache_flush_done;

    logic        IFU_valid;
    logic        IFU_ready;
    logic [31:0] IFU_pc;
    logic [31:0] IFU_inst;

    // The PC generator itself.
    modport master (
        input  dnpc_flag,
        input  dnpc,
        input  icache_clr,
        output ifu_req_valid,
        input  ifu_req_ready,
        output ifu_req_addr,
        input  ifu_rsp_valid,
        input  ifu_rsp_data,
        output icache_flush,
        input  icache_flush_done,
        output IFU_valid,
        input  IFU_ready,
        output IFU_pc,
        output IFU_inst
    );

    // The surrounding pipeline: redirect source, I-cache and IDU.
    modport slave (
        output dnpc_flag,
        output dnpc,
        output icache_clr,
        input  ifu_req_valid,
        output ifu_req_ready,
        input  ifu_req_addr,
        output ifu_rsp_valid,
        output ifu_rsp_data,
        input  icache_flush,
        output icache_flush_done,
        input  IFU_valid,
        output IFU_ready,
        input  IFU_pc,
        input  IFU_inst
    );

endinterface

// File: rtl/ifu_pc_gen.sv
// Fetch PC generator: owns the architectural fetch PC, issues one-outstanding
// I-cache fetches, drops wrong-path responses and sequences fence.i flushes.
module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    ifu_pc_gen_if.master bus
);

    ifu_state_e  state;
    logic [31:0] pc;
    logic        drop;
    logic        flush_pend;
    logic [31:0] ifu_pc_q;
    logic [31:0] ifu_inst_q;
    logic        flush_next;

    // A flush requested in the same cycle as a wrong-path response must still be honoured.
    assign flush_next = flush_pend | (bus.dnpc_flag & bus.icache_clr);

    // Outputs are decoded from state; only IFU_valid is killed combinationally by a redirect.
    assign bus.ifu_req_valid = (state == S_REQ);
    assign bus.ifu_req_addr  = (state == S_REQ) ? pc : 32'd0;
    assign bus.icache_flush  = (state == S_FLUSH);
    assign bus.IFU_valid     = (state == S_HOLD) & ~bus.dnpc_flag;
    assign bus.IFU_pc        = ifu_pc_q;
    assign bus.IFU_inst      = ifu_inst_q;

    // Fetch sequencer with PC, wrong-path and pending-flush bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            flush_pend <= 1'b0;
            ifu_pc_q   <= 32'd0;
            ifu_inst_q <= 32'd0;
        end else begin
            case (state)
                S_BOOT: begin
                    state <= S_REQ;
                end

                S_REQ: begin
                    if (bus.ifu_req_ready) begin
                        state <= S_WAIT;
                        if (bus.dnpc_flag) begin
                            drop       <= 1'b1;
                            pc         <= bus.dnpc;
                            flush_pend <= bus.icache_clr;
                        end
                    end else if (bus.dnpc_flag) begin
                        pc    <= bus.dnpc;
                        state <= bus.icache_clr ? S_FLUSH : S_REQ;
                    end
                end

                S_WAIT: begin
                    if (bus.dnpc_flag) begin
                        pc         <= bus.dnpc;
                        drop       <= 1'b1;
                        flush_pend <= flush_next;
                    end
                    if (bus.ifu_rsp_valid) begin
                        if (drop || bus.dnpc_flag) begin
                            drop  <= 1'b0;
                            state <= flush_next ? S_FLUSH : S_REQ;
                        end else begin
                            ifu_inst_q <= bus.ifu_rsp_data;
                            ifu_pc_q   <= pc;
                            pc         <= pc + IFU_PC_STEP;
                            state      <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (bus.dnpc_flag) begin
                        pc    <= bus.dnpc;
                        state <= bus.icache_clr ? S_FLUSH : S_REQ;
                    end else if (bus.IFU_ready) begin
                        state <= S_REQ;
                    end
                end

                S_FLUSH: begin
                    if (bus.dnpc_flag) begin
                        pc <= bus.dnpc;
                    end
                    if (bus.icache_flush_done) begin
                        flush_pend <= 1'b0;
                        state      <= S_REQ;
                    end
                end

                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Self-checking bench for ifu_pc_gen: directed vector table, hand-written
// wrap/reset sequences, then randomized traffic against a transaction model.
module tb_ifu_pc_gen;

    logic clock;
    logic reset;

    ifu_pc_gen_if bus ();

    ifu_pc_gen #(
        .RESET_PC(32'h8000_0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        dnpc_flag;
        logic [31:0] dnpc;
        logic        clr;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        flush_done;
        logic        ifu_ready;
        logic        e_req_valid;
        logic [31:0] e_req_addr;
        logic        e_flush;
        logic        e_ifu_valid;
        logic [31:0] e_ifu_pc;
        logic [31:0] e_ifu_inst;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[20];

    // Random-phase environment and model state.
    logic        outstanding;
    int          rsp_countdown;
    logic [31:0] pending_addr;
    logic        flush_owed;
    logic [31:0] exp_pc;
    int          deliveries;
    logic        prev_held;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    logic [31:0] tmp;

    // Instruction memory contents seen by the I-cache model.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic vec_t mk_vec(
        input logic dnpc_flag, input logic [31:0] dnpc, input logic clr,
        input logic req_ready, input logic rsp_valid, input logic [31:0] rsp_data,
        input logic flush_done, input logic ifu_ready,
        input logic e_req_valid, input logic [31:0] e_req_addr, input logic e_flush,
        input logic e_ifu_valid, input logic [31:0] e_ifu_pc, input logic [31:0] e_ifu_inst);
        vec_t v;
        v.dnpc_flag   = dnpc_flag;
        v.dnpc        = dnpc;
        v.clr         = clr;
        v.req_ready   = req_ready;
        v.rsp_valid   = rsp_valid;
        v.rsp_data    = rsp_data;
        v.flush_done  = flush_done;
        v.ifu_ready   = ifu_ready;
        v.e_req_valid = e_req_valid;
        v.e_req_addr  = e_req_addr;
        v.e_flush     = e_flush;
        v.e_ifu_valid = e_ifu_valid;
        v.e_ifu_pc    = e_ifu_pc;
        v.e_ifu_inst  = e_ifu_inst;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(
        input logic dnpc_flag, input logic [31:0] dnpc, input logic clr,
        input logic req_ready, input logic rsp_valid, input logic [31:0] rsp_data,
        input logic flush_done, input logic ifu_ready);
        bus.dnpc_flag         = dnpc_flag;
        bus.dnpc              = dnpc;
        bus.icache_clr        = clr;
        bus.ifu_req_ready     = req_ready;
        bus.ifu_rsp_valid     = rsp_valid;
        bus.ifu_rsp_data      = rsp_data;
        bus.icache_flush_done = flush_done;
        bus.IFU_ready         = ifu_ready;
    endtask

    // Drive one cycle's inputs just after the falling edge and let them settle.
    task automatic step(
        input logic dnpc_flag, input logic [31:0] dnpc, input logic clr,
        input logic req_ready, input logic rsp_valid, input logic [31:0] rsp_data,
        input logic flush_done, input logic ifu_ready);
        @(negedge clock);
        apply_stimulus(dnpc_flag, dnpc, clr, req_ready, rsp_valid, rsp_data, flush_done, ifu_ready);
        #1;
    endtask

    task automatic check_all(input string tag, input logic rv, input logic [31:0] addr,
                             input logic fl, input logic iv, input logic [31:0] ipc,
                             input logic [31:0] iinst);
        check_output({tag, ".req_valid"}, {31'd0, bus.ifu_req_valid}, {31'd0, rv});
        check_output({tag, ".req_addr"}, bus.ifu_req_addr, addr);
        check_output({tag, ".icache_flush"}, {31'd0, bus.icache_flush}, {31'd0, fl});
        check_output({tag, ".IFU_valid"}, {31'd0, bus.IFU_valid}, {31'd0, iv});
        check_output({tag, ".IFU_pc"}, bus.IFU_pc, ipc);
        check_output({tag, ".IFU_inst"}, bus.IFU_inst, iinst);
    endtask

    task automatic do_reset();
        @(negedge clock);
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Directed table: fetch, redirect in WAIT, kill in HOLD, fence.i in WAIT.
        vecs[0]  = mk_vec(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk_vec(0, 0, 0, 1, 0, 0, 0, 0,  1, 32'h8000_0000, 0, 0, 0, 0);
        vecs[2]  = mk_vec(0, 0, 0, 0, 1, 32'h0000_0013, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[3]  = mk_vec(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 32'h8000_0000, 32'h13);
        vecs[4]  = mk_vec(0, 0, 0, 1, 0, 0, 0, 0,  1, 32'h8000_0004, 0, 0, 32'h8000_0000, 32'h13);
        vecs[5]  = mk_vec(1, 32'h8000_0100, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h8000_0000, 32'h13);
        vecs[6]  = mk_vec(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 1,  0, 0, 0, 0, 32'h8000_0000, 32'h13);
        vecs[7]  = mk_vec(0, 0, 0, 1, 0, 0, 0, 0,  1, 32'h8000_0100, 0, 0, 32'h8000_0000, 32'h13);
        vecs[8]  = mk_vec(0, 0, 0, 0, 1, 32'h0010_0093, 0, 0,  0, 0, 0, 0, 32'h8000_0000, 32'h13);
        vecs[9]  = mk_vec(1, 32'h8000_0200, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[10] = mk_vec(0, 0, 0, 0, 0, 0, 1, 0,  1, 32'h8000_0200, 0, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[11] = mk_vec(0, 0, 0, 1, 0, 0, 0, 0,  1, 32'h8000_0200, 0, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[12] = mk_vec(1, 32'h8000_0040, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[13] = mk_vec(0, 0, 0, 0, 1, 32'h2222_2222, 0, 0,  0, 0, 0, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[14] = mk_vec(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[15] = mk_vec(0, 0, 0, 1, 1, 32'h3333_3333, 0, 0,  0, 0, 1, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[16] = mk_vec(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[17] = mk_vec(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[18] = mk_vec(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 32'h8000_0100, 32'h0010_0093);
        vecs[19] = mk_vec(0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0040, 0, 0, 32'h8000_0100, 32'h0010_0093);

        // All outputs are zero while reset is held.
        #2;
        check_all("in_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            if (i != 0) @(negedge clock);
            apply_stimulus(vecs[i].dnpc_flag, vecs[i].dnpc, vecs[i].clr, vecs[i].req_ready,
                           vecs[i].rsp_valid, vecs[i].rsp_data, vecs[i].flush_done, vecs[i].ifu_ready);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_req_valid, vecs[i].e_req_addr, vecs[i].e_flush,
                      vecs[i].e_ifu_valid, vecs[i].e_ifu_pc, vecs[i].e_ifu_inst);
        end

        // PC wrap: redirect to the last word, fetch it, next request must be address 0.
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        check_output("wrap.addr_before", bus.ifu_req_addr, 32'h8000_0040);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        check_output("wrap.addr_top", bus.ifu_req_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1, 32'h0000_0073, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check_output("wrap.IFU_pc", bus.IFU_pc, 32'hFFFF_FFFC);
        check_output("wrap.IFU_inst", bus.IFU_inst, 32'h0000_0073);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("wrap.req_valid", {31'd0, bus.ifu_req_valid}, 32'd1);
        check_output("wrap.addr_zero", bus.ifu_req_addr, 32'h0000_0000);

        // Asynchronous reset in the middle of S_HOLD, then stale responses after release.
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0000_0517, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("hold.IFU_valid", {31'd0, bus.IFU_valid}, 32'd1);
        check_output("hold.IFU_pc", bus.IFU_pc, 32'h0000_0000);
        check_output("hold.IFU_inst", bus.IFU_inst, 32'h0000_0517);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 1, 32'hBAD0_BAD0, 0, 0);
        #1;
        check_all("boot_stale", 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hBAD1_BAD1, 0, 0);
        check_all("req_stale", 1, 32'h8000_0000, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        check_output("post_reset.addr", bus.ifu_req_addr, 32'h8000_0000);
        step(0, 0, 0, 0, 1, 32'h0000_0297, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_all("post_reset.hold", 0, 0, 0, 1, 32'h8000_0000, 32'h0000_0297);

        // Randomized traffic checked against a transaction-level model.
        do_reset();
        outstanding   = 1'b0;
        rsp_countdown = 0;
        pending_addr  = 32'd0;
        flush_owed    = 1'b0;
        exp_pc        = 32'h8000_0000;
        deliveries    = 0;
        prev_held     = 1'b0;
        prev_pc       = 32'd0;
        prev_inst     = 32'd0;
        for (int i = 0; i < 4000; i++) begin
            logic        r_flag;
            logic        r_clr;
            logic        r_ready;
            logic        r_rsp;
            logic        r_done;
            logic        r_iready;
            logic [31:0] r_dnpc;
            if (i != 0) @(negedge clock);
            #1;
            r_flag = (i >= 2) && ($urandom_range(0, 9) == 0);
            r_clr  = r_flag && ($urandom_range(0, 2) == 0);
            tmp    = $urandom;
            case ($urandom_range(0, 7))
                0:       r_dnpc = tmp;
                1:       r_dnpc = 32'hFFFF_FFF0 | {28'd0, tmp[3:2], 2'b00};
                default: r_dnpc = {tmp[31:2], 2'b00};
            endcase
            r_ready  = ($urandom_range(0, 3) != 0);
            r_rsp    = outstanding && (rsp_countdown == 0);
            r_done   = bus.icache_flush && ($urandom_range(0, 2) == 0);
            r_iready = ($urandom_range(0, 2) != 0);
            apply_stimulus(r_flag, r_dnpc, r_clr, r_ready, r_rsp, mem_word(pending_addr), r_done, r_iready);
            #1;

            if (outstanding)
                check_output("rnd.one_outstanding", {31'd0, bus.ifu_req_valid}, 32'd0);
            if (r_flag)
                check_output("rnd.kill_on_redirect", {31'd0, bus.IFU_valid}, 32'd0);
            if (bus.icache_flush)
                check_output("rnd.flush_only_if_owed", {31'd0, flush_owed}, 32'd1);
            if (bus.ifu_req_valid && r_ready)
                check_output("rnd.no_fetch_before_flush", {31'd0, flush_owed}, 32'd0);
            if (prev_held) begin
                check_output("rnd.stable_pc", bus.IFU_pc, prev_pc);
                check_output("rnd.stable_inst", bus.IFU_inst, prev_inst);
                if (!r_flag)
                    check_output("rnd.stable_valid", {31'd0, bus.IFU_valid}, 32'd1);
            end
            if (bus.IFU_valid && r_iready) begin
                check_output("rnd.deliver_pc", bus.IFU_pc, exp_pc);
                check_output("rnd.deliver_inst", bus.IFU_inst, mem_word(exp_pc));
                deliveries++;
            end

            // Advance the model to the state after this clock edge.
            prev_held = bus.IFU_valid && !r_iready;
            prev_pc   = bus.IFU_pc;
            prev_inst = bus.IFU_inst;
            if (r_flag)
                exp_pc = r_dnpc;
            else if (bus.IFU_valid && r_iready)
                exp_pc = exp_pc + 32'd4;
            if (bus.icache_flush && r_done)
                flush_owed = 1'b0;
            else if (r_flag && r_clr)
                flush_owed = 1'b1;
            if (outstanding) begin
                if (r_rsp) outstanding = 1'b0;
                else rsp_countdown--;
            end else if (bus.ifu_req_valid && r_ready) begin
                outstanding   = 1'b1;
                pending_addr  = bus.ifu_req_addr;
                rsp_countdown = $urandom_range(0, 2);
            end
        end
        check_output("rnd.liveness", {31'd0, (deliveries >= 50)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
